dnn_ami_req_splitter: RTL and testbench

- Sits between the DNNWeaver memory port and the per-app AMI request path.
- Accepts one DNNWeaverMemReq (byte address, byte size) and splits it into a sequence of 64-byte AMIRequest beats.
- For writes, pairs each beat with one 512-bit write-data word.
- For reads, emits one DNNMicroRdTag describing the burst, consumed by the downstream read-response reassembler.

---
 rtl/dnn_ami_req_splitter_pkg.sv | 50 +++++
 rtl/dnn_ami_req_splitter.sv | 110 +++++++++++
 tb/tb_dnn_ami_req_splitter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_ami_req_splitter_pkg.sv
// Shared AMI/DNNWeaver types and constants used by the request splitter
// and the read-response reassembler.
package dnn_ami_req_splitter_pkg;

  localparam int         AMI_BEAT_BYTES      = 64;
  localparam logic [5:0] AMI_BEAT_SIZE_FULL  = 6'd0;  // size 0 encodes a full 64-byte beat
  localparam int         DNN_MAX_BEATS_WIDTH = 15;

  localparam int DNN_ADDR_W = 32;
  localparam int DNN_SIZE_W = 20;
  localparam int DNN_PU_W   = 4;
  localparam int AMI_ADDR_W = 64;
  localparam int WR_DATA_W  = 512;
  localparam int AMI_DATA_W = 576;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [DNN_ADDR_W-1:0] addr;
    logic [DNN_SIZE_W-1:0] size;
    logic [DNN_PU_W-1:0]   pu_id;
  } dnn_mem_req_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [AMI_ADDR_W-1:0] addr;
    logic [AMI_DATA_W-1:0] data;
    logic [5:0]            size;
  } ami_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DNN_ADDR_W-1:0] addr;
    logic [DNN_SIZE_W-1:0] size;
  } rd_tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } split_state_e;

  // Number of 64-byte beats needed to cover a byte count (rounded up).
  function automatic logic [DNN_MAX_BEATS_WIDTH-1:0] beats_for_size(
    input logic [DNN_SIZE_W-1:0] size
  );
    return {1'b0, size[DNN_SIZE_W-1:6]} + {{(DNN_MAX_BEATS_WIDTH-1){1'b0}}, |size[5:0]};
  endfunction

endpackage

// File: rtl/dnn_ami_req_splitter.sv
// Splits one DNNWeaver memory command into a run of 64-byte AMI beats.
// Writes pair each beat with one upstream data word; reads post a single
// burst tag for the response reassembler.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; grants it and latches the burst
// ST_ISSUE | presenting beats until the last one is accepted
module dnn_ami_req_splitter
  import dnn_ami_req_splitter_pkg::*;
#(
  parameter logic [AMI_ADDR_W-1:0] BASE_ADDR = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dnn_mem_req_t         dnn_req_in,
  output logic                 dnn_req_grant,
  input  logic [WR_DATA_W-1:0] wr_data,
  input  logic                 wr_data_valid,
  output logic                 wr_data_ready,
  output ami_req_t             ami_req_out,
  input  logic                 ami_req_grant,
  output rd_tag_t              rd_tag_out,
  input  logic                 rd_tag_grant,
  output logic                 busy
);

  localparam int BEAT_BYTES = AMI_BEAT_BYTES;

  split_state_e                   state_q, state_d;
  logic [DNN_ADDR_W-1:0]          cur_addr;
  logic [DNN_MAX_BEATS_WIDTH-1:0] beats_left;
  logic [5:0]                     tail;
  logic                           is_wr;
  rd_tag_t                        tag_q;

  logic beat_valid;
  logic beat_xfer;
  logic last_beat;
  logic unused_pu;

  assign unused_pu  = ^dnn_req_in.pu_id;
  assign beat_valid = (state_q == ST_ISSUE) && (is_wr ? wr_data_valid : 1'b1);
  assign beat_xfer  = beat_valid && ami_req_grant;
  assign last_beat  = (beats_left == {{(DNN_MAX_BEATS_WIDTH-1){1'b0}}, 1'b1});
  assign rd_tag_out = tag_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, command grant and beat presentation.
  always_comb begin
    state_d       = state_q;
    dnn_req_grant = 1'b0;
    wr_data_ready = 1'b0;
    busy          = 1'b0;
    ami_req_out   = '0;
    case (state_q)
      ST_IDLE: begin
        // A pending read tag only blocks further reads; writes never need it.
        dnn_req_grant = dnn_req_in.valid && (dnn_req_in.is_write || !tag_q.valid);
        if (dnn_req_grant && (dnn_req_in.size != '0)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy                 = 1'b1;
        ami_req_out.valid    = beat_valid;
        ami_req_out.is_write = is_wr;
        ami_req_out.addr     = BASE_ADDR + {32'b0, cur_addr};
        ami_req_out.size     = (last_beat && (tail != 6'd0)) ? tail : AMI_BEAT_SIZE_FULL;
        if (is_wr) ami_req_out.data = {64'b0, wr_data};
        wr_data_ready        = is_wr && ami_req_grant && wr_data_valid;
        if (beat_xfer && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst address and beat counters: loaded on grant, stepped per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      tail       <= '0;
      is_wr      <= 1'b0;
    end else if (dnn_req_grant) begin
      cur_addr   <= {dnn_req_in.addr[DNN_ADDR_W-1:6], 6'b0};
      beats_left <= beats_for_size(dnn_req_in.size);
      tail       <= dnn_req_in.size[5:0];
      is_wr      <= dnn_req_in.is_write;
    end else if (beat_xfer) begin
      cur_addr   <= cur_addr + 32'(BEAT_BYTES);
      beats_left <= beats_left - 1'b1;
    end
  end

  // Read-burst tag: captured with the original address/size, held until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (dnn_req_grant && !dnn_req_in.is_write && (dnn_req_in.size != '0)) begin
      tag_q <= '{valid: 1'b1, addr: dnn_req_in.addr, size: dnn_req_in.size};
    end else if (tag_q.valid && rd_tag_grant) begin
      tag_q.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dnn_ami_req_splitter.sv
// Scoreboard bench for the DNN-to-AMI request splitter.
module tb_dnn_ami_req_splitter;
  import dnn_ami_req_splitter_pkg::*;

  localparam logic [63:0] TB_BASE = 64'h0000_0040_0000_0000;
  localparam int          BW      = $bits(ami_req_t);

  logic           clk;
  logic           rst;
  dnn_mem_req_t   dnn_req_in;
  logic           dnn_req_grant;
  logic [511:0]   wr_data;
  logic           wr_data_valid;
  logic           wr_data_ready;
  ami_req_t       ami_req_out;
  logic           ami_req_grant;
  rd_tag_t        rd_tag_out;
  logic           rd_tag_grant;
  logic           busy;

  dnn_ami_req_splitter #(.BASE_ADDR(TB_BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .dnn_req_in    (dnn_req_in),
    .dnn_req_grant (dnn_req_grant),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .ami_req_out   (ami_req_out),
    .ami_req_grant (ami_req_grant),
    .rd_tag_out    (rd_tag_out),
    .rd_tag_grant  (rd_tag_grant),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  ami_req_t     exp_beats[$];
  rd_tag_t      exp_tags[$];
  logic [511:0] wr_q[$];

  bit wr_gate    = 1'b1;
  bit grant_rand = 1'b0;
  bit wr_took    = 1'b0;
  int beat_cnt   = 0;
  int wr_rdy_cnt = 0;
  int busy_cnt   = 0;

  // Upstream write-data source and downstream beat grant.
  initial begin
    ami_req_grant = 1'b1;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_took && wr_q.size() > 0) void'(wr_q.pop_front());
      wr_took       = 1'b0;
      wr_data_valid = wr_gate && (wr_q.size() > 0);
      wr_data       = (wr_q.size() > 0) ? wr_q[0] : '0;
      ami_req_grant = grant_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: beats, tags, stall stability, write-ready pulses.
  ami_req_t stall_q;
  bit       stall_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (stall_v && ami_req_out.valid) chk("hold_stable", ami_req_out, stall_q);
      stall_v = ami_req_out.valid && !ami_req_grant;
      stall_q = ami_req_out;
      if (ami_req_out.valid && ami_req_grant) begin
        beat_cnt++;
        if (exp_beats.size() == 0) chk("unexpected_beat", BW'(1), BW'(0));
        else chk("beat", ami_req_out, exp_beats.pop_front());
        if (ami_req_out.is_write) begin
          chk("wr_ready_on_beat", BW'(wr_data_ready), BW'(1));
          wr_took = 1'b1;
        end
      end
      if (wr_data_ready) begin
        wr_rdy_cnt++;
        if (!(ami_req_out.valid && ami_req_grant && ami_req_out.is_write))
          chk("wr_ready_spurious", BW'(1), BW'(0));
      end
      if (rd_tag_out.valid && rd_tag_grant) begin
        if (exp_tags.size() == 0) chk("unexpected_tag", BW'(1), BW'(0));
        else chk("rd_tag", BW'(rd_tag_out), BW'(exp_tags.pop_front()));
      end
    end
  end

  // Reference model: expected beats, write words and read tag for one command.
  task automatic push_expect(input bit w, input logic [31:0] a, input logic [19:0] s);
    int           n;
    logic [31:0]  ba;
    ami_req_t     b;
    logic [511:0] wd;
    n  = (int'(s) + 63) / 64;
    ba = a & 32'hFFFF_FFC0;
    for (int i = 0; i < n; i++) begin
      b          = '0;
      b.valid    = 1'b1;
      b.is_write = w;
      b.addr     = TB_BASE + {32'h0, ba};
      b.size     = ((i == n - 1) && (s % 20'd64 != 0)) ? 6'(s % 20'd64) : 6'd0;
      if (w) begin
        for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
        wr_q.push_back(wd);
        b.data = {64'h0, wd};
      end
      exp_beats.push_back(b);
      ba = ba + 32'd64;
    end
    if (!w && s != 0) exp_tags.push_back('{valid: 1'b1, addr: a, size: s});
  endtask

  task automatic issue_cmd(input bit w, input logic [31:0] a, input logic [19:0] s,
                           output int waited);
    waited = 0;
    @(posedge clk);
    #1;
    dnn_req_in          = '0;
    dnn_req_in.valid    = 1'b1;
    dnn_req_in.is_write = w;
    dnn_req_in.addr     = a;
    dnn_req_in.size     = s;
    dnn_req_in.pu_id    = 4'hA;
    forever begin
      @(negedge clk);
      if (dnn_req_grant) break;
      waited++;
      if (waited >= 60) begin
        chk("grant_timeout", BW'(0), BW'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    if (dnn_req_grant) push_expect(w, a, s);
    @(posedge clk);
    #1;
    dnn_req_in = '0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      if (exp_beats.size() == 0 && !busy) break;
      c++;
    end
    if (c >= 300) chk("idle_timeout", BW'(0), BW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int wb;
    int b0;
    int c;
    rst          = 1'b1;
    dnn_req_in   = '0;
    rd_tag_grant = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ami_req", ami_req_out, '0);
    chk("rst_rd_tag", BW'(rd_tag_out), '0);
    chk("rst_grant", BW'(dnn_req_grant), '0);
    chk("rst_wr_ready", BW'(wr_data_ready), '0);
    chk("rst_busy", BW'(busy), '0);
    rst = 1'b0;

    // Read 256 bytes at 0x1000 with continuous grant.
    busy_cnt = 0;
    b0 = beat_cnt;
    issue_cmd(1'b0, 32'h1000, 20'd256, w);
    chk("t1_wait", BW'(w), BW'(0));
    @(negedge clk);
    chk("t1_tag_valid", BW'(rd_tag_out.valid), BW'(1));
    wait_idle();
    chk("t1_beats", BW'(beat_cnt - b0), BW'(4));
    chk("t1_busy_cycles", BW'(busy_cnt), BW'(4));

    // Write 100 bytes at unaligned 0x2010.
    wr_rdy_cnt = 0;
    b0 = beat_cnt;
    issue_cmd(1'b1, 32'h2010, 20'd100, w);
    wait_idle();
    chk("t2_beats", BW'(beat_cnt - b0), BW'(2));
    chk("t2_wr_ready", BW'(wr_rdy_cnt), BW'(2));

    // Write with a 3-cycle data gap and a toggling downstream grant.
    grant_rand = 1'b1;
    wr_rdy_cnt = 0;
    b0 = beat_cnt;
    issue_cmd(1'b1, 32'h3000, 20'd400, w);
    repeat (2) @(negedge clk);
    wr_gate = 1'b0;
    repeat (3) @(negedge clk);
    wr_gate = 1'b1;
    wait_idle();
    grant_rand = 1'b0;
    chk("t3_beats", BW'(beat_cnt - b0), BW'(7));
    chk("t3_wr_ready", BW'(wr_rdy_cnt), BW'(7));

    // Pending read tag blocks reads but not writes.
    rd_tag_grant = 1'b0;
    issue_cmd(1'b0, 32'h4000, 20'd128, w);
    wait_idle();
    issue_cmd(1'b1, 32'h5000, 20'd64, w);
    chk("t4_write_not_blocked", BW'(w), BW'(0));
    wait_idle();
    fork
      issue_cmd(1'b0, 32'h6000, 20'd192, wb);
      begin
        repeat (3) @(posedge clk);
        #1;
        rd_tag_grant = 1'b1;
      end
    join
    chk("t4_read_b_wait", BW'(wb), BW'(3));
    wait_idle();

    // Zero-size read is granted and dropped.
    b0 = beat_cnt;
    issue_cmd(1'b0, 32'h7000, 20'd0, w);
    chk("t5_zero_wait", BW'(w), BW'(0));
    repeat (4) @(negedge clk);
    chk("t5_zero_beats", BW'(beat_cnt - b0), BW'(0));
    chk("t5_zero_tag", BW'(rd_tag_out.valid), BW'(0));
    chk("t5_zero_busy", BW'(busy), BW'(0));

    // Address wrap at the top of the 32-bit space.
    b0 = beat_cnt;
    issue_cmd(1'b0, 32'hFFFF_FFC0, 20'd128, w);
    wait_idle();
    chk("t5_wrap_beats", BW'(beat_cnt - b0), BW'(2));

    // Reset after 2 of 8 beats abandons the burst.
    rd_tag_grant = 1'b0;
    b0 = beat_cnt;
    issue_cmd(1'b0, 32'h8000, 20'd512, w);
    c = 0;
    while (c < 50) begin
      @(posedge clk);
      if (beat_cnt >= b0 + 2) break;
      c++;
    end
    if (c >= 50) chk("t6_beat_timeout", BW'(0), BW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_ami_req", ami_req_out, '0);
    chk("t6_rst_rd_tag", BW'(rd_tag_out), '0);
    chk("t6_rst_busy", BW'(busy), '0);
    chk("t6_rst_wr_ready", BW'(wr_data_ready), '0);
    chk("t6_rst_grant", BW'(dnn_req_grant), '0);
    exp_beats.delete();
    exp_tags.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    rd_tag_grant = 1'b1;
    b0 = beat_cnt;
    wr_rdy_cnt = 0;
    issue_cmd(1'b1, 32'h9000, 20'd130, w);
    chk("t6_after_rst_wait", BW'(w), BW'(0));
    wait_idle();
    chk("t6_after_rst_beats", BW'(beat_cnt - b0), BW'(3));
    chk("t6_after_rst_wr_ready", BW'(wr_rdy_cnt), BW'(3));

    repeat (3) @(negedge clk);
    chk("end_beats_drained", BW'(exp_beats.size()), BW'(0));
    chk("end_tags_drained", BW'(exp_tags.size()), BW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
